// File: rtl/datapath_sequencer_pkg.sv
// datapath_sequencer_pkg: shared state encoding, opcodes and default RF slots for the datapath sequencer.
package datapath_sequencer_pkg;
  localparam int DEF_WORDSIZE = 64;
  localparam logic [4:0] DEF_RF_SLOT_A = 5'd0;
  localparam logic [4:0] DEF_RF_SLOT_B = 5'd1;
  localparam logic [4:0] DEF_RF_SLOT_R = 5'd2;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    RD_A = 4'd1,
    WB_A = 4'd2,
    RD_B = 4'd3,
    WB_B = 4'd4,
    EXEC = 4'd5,
    WB_R = 4'd6,
    ST   = 4'd7,
    DONE = 4'd8
  } state_e;
endpackage

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: start/busy/done controller moving two DM operands through the RF and adder back to DM.
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int WORDSIZE = DEF_WORDSIZE,
  parameter logic [4:0] RF_SLOT_A = DEF_RF_SLOT_A,
  parameter logic [4:0] RF_SLOT_B = DEF_RF_SLOT_B,
  parameter logic [4:0] RF_SLOT_R = DEF_RF_SLOT_R
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic [4:0]          src_a,
  input  logic [4:0]          src_b,
  input  logic [4:0]          dst,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] result,
  output logic                overflow,
  output logic [4:0]          dm_addr,
  output logic [WORDSIZE-1:0] dm_data_input,
  output logic                dm_write_enable,
  output logic                dm_read,
  input  logic [WORDSIZE-1:0] dm_data_output,
  output logic                rf_write_en,
  output logic [4:0]          rf_write_addr,
  output logic [WORDSIZE-1:0] rf_write_data,
  output logic [4:0]          rf_addr_a,
  output logic [4:0]          rf_addr_b,
  input  logic [WORDSIZE-1:0] rf_data_a,
  input  logic [WORDSIZE-1:0] rf_data_b,
  output logic [WORDSIZE-1:0] factor_a,
  output logic [WORDSIZE-1:0] factor_b,
  output logic                operation,
  input  logic [WORDSIZE-1:0] adder_result
);
  state_e state_q, state_d;
  logic op_q;
  logic [4:0] src_a_q, src_b_q, dst_q;
  logic [WORDSIZE-1:0] result_q, factor_a_q, factor_b_q;
  logic overflow_q, ovf;
  logic sign_a, sign_b, sign_r;
  assign sign_a = factor_a_q[WORDSIZE-1];
  assign sign_b = factor_b_q[WORDSIZE-1];
  assign sign_r = adder_result[WORDSIZE-1];
  // subtraction overflows when operand signs differ, addition when they match
  assign ovf = ((op_q == OP_SUB) ? (sign_a != sign_b) : (sign_a == sign_b)) && (sign_r != sign_a);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dst_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      factor_a_q <= '0;
      factor_b_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        op_q    <= op;
        src_a_q <= src_a;
        src_b_q <= src_b;
        dst_q   <= dst;
      end
      if (state_q == EXEC) begin
        factor_a_q <= rf_data_a;
        factor_b_q <= rf_data_b;
      end
      if (state_q == WB_R) begin
        result_q   <= adder_result;
        overflow_q <= ovf;
      end
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? RD_A : IDLE) :
              (state_q == DONE) ? IDLE : state_e'(state_q + 4'd1);
    busy = state_q != IDLE;
    done = state_q == DONE;
    dm_read = (state_q == RD_A) || (state_q == RD_B);
    dm_write_enable = state_q == ST;
    dm_addr = (state_q == RD_A) ? src_a_q :
              (state_q == RD_B) ? src_b_q :
              (state_q == ST)   ? dst_q : 5'd0;
    dm_data_input = (state_q == ST) ? result_q : '0;
    rf_write_en = (state_q == WB_A) || (state_q == WB_B) || (state_q == WB_R);
    rf_write_addr = (state_q == WB_A) ? RF_SLOT_A :
                    (state_q == WB_B) ? RF_SLOT_B :
                    (state_q == WB_R) ? RF_SLOT_R : 5'd0;
    rf_write_data = (state_q == WB_R) ? adder_result :
                    ((state_q == WB_A) || (state_q == WB_B)) ? dm_data_output : '0;
    rf_addr_a = (state_q == EXEC) ? RF_SLOT_A : 5'd0;
    rf_addr_b = (state_q == EXEC) ? RF_SLOT_B : 5'd0;
  end
  assign factor_a  = factor_a_q;
  assign factor_b  = factor_b_q;
  assign operation = op_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: random and directed commands against a DM/RF/adder environment with a scoreboarded reference model.
module tb_datapath_sequencer;
  localparam int W = 64;
  localparam logic [4:0] SLOT_R = 5'd2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic op = 1'b0;
  logic [4:0] src_a = '0, src_b = '0, dst = '0;
  logic busy, done, overflow, dm_write_enable, dm_read, rf_write_en, operation;
  logic [W-1:0] result, dm_data_input, rf_write_data, factor_a, factor_b;
  logic [W-1:0] dm_data_output, rf_data_a, rf_data_b, adder_result;
  logic [4:0] dm_addr, rf_write_addr, rf_addr_a, rf_addr_b;
  logic [W-1:0] dm [32];
  logic [W-1:0] rf [32];
  logic [W-1:0] ref_dm [32];
  logic pre_we = 1'b0;
  logic [4:0] pre_addr = '0;
  logic [W-1:0] pre_data = '0;
  logic dir_v = 1'b0, dir_ov = 1'b0;
  logic [W-1:0] dir_r = '0;
  logic final_chk = 1'b0, end_req = 1'b0;
  int vectors = 0, miscompares = 0, cyc = 0, busy_cnt = 0;
  logic rst_prev = 1'b0, prev_done = 1'b0;
  typedef struct {
    logic [W-1:0] r;
    logic ov;
    logic [4:0] dst;
    int acc;
  } exp_t;
  exp_t q[$];

  datapath_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .dm_addr(dm_addr), .dm_data_input(dm_data_input), .dm_write_enable(dm_write_enable),
    .dm_read(dm_read), .dm_data_output(dm_data_output),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .factor_a(factor_a), .factor_b(factor_b), .operation(operation), .adder_result(adder_result)
  );

  always #5 clk = ~clk;

  // environment: registered-read data memory, combinational-read register file, adder
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) dm[pre_addr] <= pre_data;
    if (dm_write_enable) dm[dm_addr] <= dm_data_input;
    if (dm_read) dm_data_output <= dm[dm_addr];
    if (rf_write_en) rf[rf_write_addr] <= rf_write_data;
  end
  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];
  assign adder_result = operation ? factor_a - factor_b : factor_a + factor_b;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] a, b;
    logic [W:0] full;
    if (rst_prev) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_overflow", overflow, 0);
    end
    if (!busy) chk("idle_enables", {dm_read, dm_write_enable, rf_write_en, done}, 0);
    chk("rd_wr_exclusive", dm_read & dm_write_enable, 0);
    busy_cnt = busy ? busy_cnt + 1 : 0;
    if (busy_cnt == 21) chk("busy_timeout", busy_cnt, 20);
    if (!rst_n) q.delete();
    else begin
      if (done) begin
        chk("done_width", prev_done, 0);
        chk("done_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("result", result, e.r);
          chk("overflow", overflow, e.ov);
          chk("dm_dst", dm[e.dst], e.r);
          chk("rf_slot_r", rf[SLOT_R], e.r);
          chk("latency", 64'(cyc), 64'(e.acc + 8));
          if (dir_v) begin
            chk("dir_result", result, dir_r);
            chk("dir_overflow", overflow, dir_ov);
          end
          ref_dm[e.dst] = e.r;
        end
      end
      if (start && !busy) begin
        a = ref_dm[src_a];
        b = ref_dm[src_b];
        full = op ? {a[W-1], a} - {b[W-1], b} : {a[W-1], a} + {b[W-1], b};
        e.r = full[W-1:0];
        e.ov = full[W] != full[W-1];
        e.dst = dst;
        e.acc = cyc;
        q.push_back(e);
      end
    end
    if (pre_we) ref_dm[pre_addr] = pre_data;
    if (final_chk) for (int i = 0; i < 32; i++) chk("dm_final", dm[i], ref_dm[i]);
    if (end_req) chk("pending", q.size(), 0);
    rst_prev = !rst_n;
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] ad, input logic [W-1:0] v);
    pre_we = 1'b1;
    pre_addr = ad;
    pre_data = v;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic o, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    start = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    dst = d;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && busy; i++) tick();
  endtask

  task automatic check_mem();
    final_chk = 1'b1;
    tick();
    final_chk = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_word();
    int k;
    k = $urandom_range(0, 7);
    return (k == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : (k == 1) ? 64'h8000_0000_0000_0000 :
           (k == 2) ? '1 : (k == 3) ? 64'd0 : {$urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) preload(5'(i), rnd_word());
    preload(5'd3, 64'd5);
    preload(5'd4, 64'd7);
    dir_v = 1'b1; dir_r = 64'd12; dir_ov = 1'b0;
    issue(1'b0, 5'd3, 5'd4, 5'd9);
    wait_idle();
    preload(5'd1, 64'd10);
    preload(5'd2, 64'd25);
    dir_r = 64'hFFFF_FFFF_FFFF_FFF1; dir_ov = 1'b0;
    issue(1'b1, 5'd1, 5'd2, 5'd1);
    wait_idle();
    preload(5'd0, 64'h7FFF_FFFF_FFFF_FFFF);
    preload(5'd5, 64'd1);
    dir_r = 64'h8000_0000_0000_0000; dir_ov = 1'b1;
    issue(1'b0, 5'd0, 5'd5, 5'd12);
    wait_idle();
    dir_v = 1'b0;
    // second start during RD_B must be ignored
    issue(1'b0, 5'd6, 5'd7, 5'd8);
    tick();
    tick();
    start = 1'b1; op = 1'b1; src_a = 5'd20; src_b = 5'd21; dst = 5'd22;
    tick();
    start = 1'b0;
    wait_idle();
    repeat (3) tick();
    check_mem();
    // reset while in EXEC aborts the command before any result write
    issue(1'b1, 5'd10, 5'd11, 5'd13);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_mem();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) preload(5'($urandom_range(0, 31)), rnd_word());
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      wait_idle();
    end
    start = 1'b1;
    for (int n = 0; n < 45; n++) begin
      op = 1'($urandom_range(0, 1));
      src_a = 5'($urandom_range(0, 31));
      src_b = 5'($urandom_range(0, 31));
      dst = 5'($urandom_range(0, 31));
      tick();
    end
    start = 1'b0;
    wait_idle();
    check_mem();
    end_req = 1'b1;
    tick();
    end_req = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
